// File: rtl/regfile_sequencer_pkg.sv
// Shared constants and state encoding for the register-file dump/load sequencer.
package regfile_sequencer_pkg;

  localparam int DEF_NUM_REGS = 4;
  localparam int DEF_ADDR_W   = 2;
  localparam int DEF_DATA_W   = 8;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DUMP_READ  = 3'd1,
    ST_DUMP_SEND  = 3'd2,
    ST_LOAD_RECV  = 3'd3,
    ST_LOAD_WRITE = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

endpackage

// File: rtl/regfile_sequencer.sv
// Walks every register-file entry in ascending order, either streaming the
// contents out (dump) or filling them from an input stream (load).
module regfile_sequencer
  import regfile_sequencer_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_enable,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic last_idx;
  assign last_idx = (idx_q == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register here is cleared by the async reset so outputs drop at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      wdata_q     <= wdata_d;
    end
  end

  // NOTE: every next-state variable holds its current value by default before
  // the case statement, so no path through the block can infer a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    wdata_d     = wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = mode ? ST_LOAD_RECV : ST_DUMP_READ;
        end
      end

      ST_DUMP_READ: begin
        out_data_d  = rf_read_data;
        out_valid_d = 1'b1;
        state_d     = ST_DUMP_SEND;
      end

      ST_DUMP_SEND: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (last_idx) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = ST_DUMP_READ;
          end
        end
      end

      ST_LOAD_RECV: begin
        if (in_valid) begin
          wdata_d = in_data;
          state_d = ST_LOAD_WRITE;
        end
      end

      ST_LOAD_WRITE: begin
        // The walk stops at the last entry rather than wrapping idx back to 0.
        if (last_idx) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + ADDR_W'(1);
          state_d = ST_LOAD_RECV;
        end
      end

      ST_DONE: begin
        idx_d   = '0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_DONE);
  assign in_ready        = (state_q == ST_LOAD_RECV);
  assign rf_write_enable = (state_q == ST_LOAD_WRITE);
  assign rf_read_addr    = idx_q;
  assign rf_write_addr   = idx_q;
  assign rf_write_data   = wdata_q;
  assign out_data        = out_data_q;
  assign out_valid       = out_valid_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomised self-checking bench: a small register-file model sits beside the
// sequencer and an array-based reference predicts stream contents and timing.
module tb_regfile_sequencer;

  localparam int NR = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, mode;
  logic       busy, done;
  logic [1:0] rf_read_addr, rf_write_addr;
  logic [7:0] rf_read_data, rf_write_data;
  logic       rf_write_enable;
  logic [7:0] out_data;
  logic       out_valid, out_ready;
  logic [7:0] in_data;
  logic       in_valid, in_ready;

  logic [7:0] rf_mem     [NR];
  logic [7:0] model_regs [NR];
  logic [7:0] load_bytes [NR];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .mode            (mode),
    .busy            (busy),
    .done            (done),
    .rf_read_addr    (rf_read_addr),
    .rf_read_data    (rf_read_data),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .rf_write_enable (rf_write_enable),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready)
  );

  assign rf_read_data = rf_mem[rf_read_addr];

  always @(posedge clk) begin
    if (rf_write_enable) rf_mem[rf_write_addr] <= rf_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_done"},  done, 0);
    check({tag, "_ovld"},  out_valid, 0);
    check({tag, "_odata"}, out_data, 0);
    check({tag, "_irdy"},  in_ready, 0);
    check({tag, "_wen"},   rf_write_enable, 0);
    check({tag, "_wdata"}, rf_write_data, 0);
    check({tag, "_raddr"}, rf_read_addr, 0);
  endtask

  // Caller is positioned at a negedge; start is raised here and sampled at the next posedge.
  task automatic dump_op(input int stall_byte, input int stall_len, input bit rand_ready,
                         input int exp_busy);
    logic [7:0] got_q[$];
    logic [7:0] held = '0;
    bit holding  = 0;
    bit finished = 0;
    int busy_cyc = 0, done_cnt = 0, first_valid = -1, last_hs = -1, done_cyc = -1;
    int stall_left = stall_len;
    start = 1'b1; mode = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 300; cyc++) begin
      if (!busy) begin
        finished = 1;
        break;
      end
      busy_cyc++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      check("dump_addr_eq", rf_write_addr, rf_read_addr);
      check("dump_no_wen", rf_write_enable, 0);
      check("dump_no_irdy", in_ready, 0);
      if (holding) begin
        check("dump_valid_hold", out_valid, 1);
        check("dump_data_hold", out_data, held);
      end
      if (out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (got_q.size() == stall_byte && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (out_ready) begin
          check("dump_addr_order", rf_read_addr, got_q.size());
          got_q.push_back(out_data);
          holding = 0;
          last_hs = cyc;
        end else begin
          holding = 1;
          held    = out_data;
        end
      end else begin
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
    end
    out_ready = 1'b0;
    check("dump_finished", finished, 1);
    check("dump_count", got_q.size(), NR);
    for (int i = 0; i < NR && i < got_q.size(); i++) check("dump_byte", got_q[i], model_regs[i]);
    check("dump_first_valid", first_valid, 2);
    check("dump_done_cnt", done_cnt, 1);
    check("dump_done_after_hs", done_cyc, last_hs + 1);
    if (exp_busy >= 0) check("dump_busy_cycles", busy_cyc, exp_busy);
  endtask

  // Streams load_bytes in; abort_idx >= 0 fires reset mid-cycle during that entry's write.
  task automatic load_op(input bit rand_valid, input bit poke_start, input int abort_idx);
    int sent = 0, wen_cnt = 0, done_cnt = 0;
    bit finished = 0, aborted = 0;
    start = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc < 300; cyc++) begin
      if (!busy) begin
        finished = 1;
        break;
      end
      if (done) done_cnt++;
      check("load_no_ovld", out_valid, 0);
      check("load_addr_eq", rf_write_addr, rf_read_addr);
      if (rf_write_enable) begin
        check("load_waddr", rf_write_addr, wen_cnt);
        check("load_wdata", rf_write_data, load_bytes[wen_cnt % NR]);
        check("load_irdy_low", in_ready, 0);
        if (wen_cnt == abort_idx) begin
          #2 reset = 1'b1;
          #1 check_idle_outputs("abort");
          @(negedge clk);
          reset   = 1'b0;
          aborted = 1;
          break;
        end
        wen_cnt++;
      end
      if (sent < NR) begin
        in_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
        in_data  = load_bytes[sent];
        if (in_valid && in_ready) sent++;
      end else begin
        in_valid = 1'b0;
      end
      if (poke_start) begin
        start = 1'($urandom_range(0, 1));
        mode  = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0;
    if (aborted) begin
      for (int i = 0; i < abort_idx; i++) model_regs[i] = load_bytes[i];
    end else begin
      check("load_finished", finished, 1);
      check("load_wen_cnt", wen_cnt, NR);
      check("load_done_cnt", done_cnt, 1);
      for (int i = 0; i < NR; i++) model_regs[i] = load_bytes[i];
    end
    for (int i = 0; i < NR; i++) check("load_rf_contents", rf_mem[i], model_regs[i]);
  endtask

  task automatic random_bytes();
    for (int i = 0; i < NR; i++) load_bytes[i] = 8'($urandom);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < NR; i++) begin
      rf_mem[i]     = 8'(8'h11 * (i + 1));
      model_regs[i] = 8'(8'h11 * (i + 1));
    end
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    // Start raised in the same negedge as reset release: accepted at the first posedge.
    dump_op(-1, 0, 1'b0, 9);
    dump_op(2, 5, 1'b0, 14);

    load_bytes[0] = 8'hA0; load_bytes[1] = 8'hB1;
    load_bytes[2] = 8'hC2; load_bytes[3] = 8'hD3;
    load_op(1'b0, 1'b1, -1);
    dump_op(-1, 0, 1'b0, 9);

    for (int r = 0; r < 4; r++) begin
      random_bytes();
      load_op(1'b1, 1'b1, -1);
      dump_op(-1, 0, 1'b1, -1);
    end

    random_bytes();
    load_op(1'b0, 1'b0, 2);
    dump_op(-1, 0, 1'b0, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
